otter_dmem_arbiter: RTL
=======================

# otter_dmem_arbiter

Two-master arbiter for the OTTER data memory port (port 2). It shares the read/write data port between the CPU writeback stage and a secondary DMA/loader master. It sequences the memory's registered read so the address, size and sign stay stable while the memory's combinational output slicer is active. Fixed CPU priority, with a starvation limit that forces a DMA grant.

## Interface
- STARVE_LIMIT, 4: consecutive CPU grants allowed while DMA_REQ is pending; the next grant then goes to the DMA master (≥1).
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CPU_REQ  in  1  CPU access request; held with its fields until CPU_GNT.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_ADDR  in  32  byte address.
- CPU_DIN  in  32  write data.
- CPU_SIZE  in  2  0 = byte, 1 = half, 2 = word.
- CPU_SIGN  in  1  1 = zero-extend (unsigned load).
- CPU_GNT  out  1  request accepted this cycle.
- CPU_RVALID  out  1  one-cycle pulse; CPU_RDATA is valid.
- CPU_RDATA  out  32  registered load data.
- DMA_REQ, DMA_WE, DMA_ADDR, DMA_DIN, DMA_SIZE, DMA_SIGN, DMA_GNT, DMA_RVALID, DMA_RDATA: same widths and meaning as the CPU_ ports, for the DMA master.
- MEM_ADDR2  out  32  memory data-port address.
- MEM_DIN2  out  32  memory write data.
- MEM_WRITE2  out  1  memory write strobe.
- MEM_READ2  out  1  memory read strobe.
- MEM_SIZE  out  2  access size.
- MEM_SIGN  out  1  unsigned-load flag.
- MEM_DOUT2  in  32  sliced read data, valid in the cycle after MEM_READ2.

## Operation
- States: IDLE, RD_WAIT.
- IDLE arbitration (combinational):
  - DMA wins if DMA_REQ is high and either CPU_REQ is low or starve_cnt == STARVE_LIMIT.
  - Otherwise CPU wins if CPU_REQ is high.
- Winner's address, data, size and sign drive the MEM_* ports directly. Its GNT is asserted.
- Winner's WE selects the strobe: 1 drives MEM_WRITE2 = 1, 0 drives MEM_READ2 = 1.
- Write grant: the transaction completes in that cycle; state stays IDLE.
- Read grant: latch addr, size, sign and owner into registers; go to RD_WAIT.
- RD_WAIT:
  - MEM_ADDR2, MEM_SIZE and MEM_SIGN come from the latched registers.
  - MEM_READ2 = 0, MEM_WRITE2 = 0, no GNT.
  - At the cycle end, MEM_DOUT2 is captured into the owner's RDATA and the owner's RVALID pulses for the next cycle. Return to IDLE.
- Idle MEM_* values: ADDR 0, DIN 0, WRITE2 0, READ2 0, SIZE 2, SIGN 0.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments on a CPU grant while DMA_REQ is high.
  - Clears on a DMA grant, or in any cycle where DMA_REQ is low.
  - Saturates at STARVE_LIMIT.
- IO region (addresses ≥ 0x11000000): handled transparently. The memory itself converts writes to IO_WR and returns the IO buffer on reads; the arbiter sequences them identically.
- RDATA holds its last captured value until the next capture for that master.

## Timing
- Reset values: state IDLE, starve_cnt 0, both GNT 0, both RVALID 0, both RDATA 0, MEM_* at idle values.
- Write latency: issued in the grant cycle. One write per cycle is sustained.
- Read latency:
  - Grant at cycle N.
  - RD_WAIT at N+1.
  - RVALID and RDATA at N+2.
- Read throughput is one read per 2 cycles. A new grant may occur in the same cycle as a RVALID pulse.
- Simultaneous requests: CPU wins unless starve_cnt == STARVE_LIMIT.
- Requests arriving in RD_WAIT wait; the requester holds them. Arbitration resumes at N+2.
- Dropping REQ before GNT: withdraws the request. Not an error.
- Reset mid-read:
  - Return to IDLE; the pending read is discarded; no RVALID.
  - MEM_READ2 and MEM_WRITE2 are 0 immediately on RST_N low.

## Test plan
- CPU lw at 0x100 with memory word 0xDEADBEEF: CPU_GNT at N; MEM_ADDR2 = 0x100 at N and N+1; CPU_RVALID = 1 and CPU_RDATA = 0xDEADBEEF at N+2; DMA_RVALID stays 0.
- DMA sb of 0xA5 to 0x203, then DMA lbu at 0x203: the write completes in its grant cycle with MEM_SIZE = 0; the read returns DMA_RDATA = 0x000000A5.
- CPU_REQ and DMA_REQ both held high, writes only, STARVE_LIMIT = 4: grants go CPU ×4, DMA ×1, CPU ×4, …
- CPU read grant followed immediately by a DMA write request: DMA_GNT is held off during RD_WAIT and asserted in the same cycle as CPU_RVALID.
- Assert RST_N low in RD_WAIT: state IDLE, MEM_READ2 = 0, no RVALID pulse after release, starve_cnt = 0.
- CPU sw to 0x11000000: MEM_WRITE2 = 1 and MEM_ADDR2 = 0x11000000 in the grant cycle (the memory raises IO_WR); single-cycle completion.

Source files
------------

// File: rtl/otter_dmem_arbiter_if.sv
// rtl/otter_dmem_arbiter_if.sv - request/grant and memory data-port bundle for the dmem arbiter
interface otter_dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_din;
    logic [1:0]  cpu_size;
    logic        cpu_sign;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_din;
    logic [1:0]  dma_size;
    logic        dma_sign;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic [31:0] mem_addr2;
    logic [31:0] mem_din2;
    logic        mem_write2;
    logic        mem_read2;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout2;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_size, cpu_sign,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_din, dma_size, dma_sign,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign,
        input  mem_dout2
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_size, cpu_sign,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_din, dma_size, dma_sign,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr2, mem_din2, mem_write2, mem_read2, mem_size, mem_sign,
        output mem_dout2
    );
endinterface

// File: rtl/otter_dmem_arbiter.sv
// rtl/otter_dmem_arbiter.sv - CPU-priority two-master arbiter for the OTTER data memory port
// Reads hold address/size/sign for one extra cycle so the memory's output slicer sees stable inputs.
module otter_dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    otter_dmem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   rd_addr_q, rd_addr_d;
    logic [1:0]    rd_size_q, rd_size_d;
    logic          rd_sign_q, rd_sign_d;
    logic          rd_owner_q, rd_owner_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          dma_rvalid_q, dma_rvalid_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dma_rdata_q, dma_rdata_d;

    logic          dma_win;
    logic          cpu_win;
    logic          win_we;
    logic [31:0]   win_addr;
    logic [31:0]   win_din;
    logic [1:0]    win_size;
    logic          win_sign;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        rd_addr_d    = rd_addr_q;
        rd_size_d    = rd_size_q;
        rd_sign_d    = rd_sign_q;
        rd_owner_d   = rd_owner_q;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        dma_win      = 1'b0;
        cpu_win      = 1'b0;

        bus.cpu_gnt    = 1'b0;
        bus.dma_gnt    = 1'b0;
        bus.mem_addr2  = 32'h0;
        bus.mem_din2   = 32'h0;
        bus.mem_write2 = 1'b0;
        bus.mem_read2  = 1'b0;
        bus.mem_size   = 2'd2;
        bus.mem_sign   = 1'b0;

        // Grants are gated by rst_n so the strobes drop the moment reset asserts.
        if (state_q == IDLE && rst_n) begin
            dma_win = bus.dma_req && (!bus.cpu_req || starve_q == LIMIT);
            cpu_win = bus.cpu_req && !dma_win;
        end

        win_we   = dma_win ? bus.dma_we   : bus.cpu_we;
        win_addr = dma_win ? bus.dma_addr : bus.cpu_addr;
        win_din  = dma_win ? bus.dma_din  : bus.cpu_din;
        win_size = dma_win ? bus.dma_size : bus.cpu_size;
        win_sign = dma_win ? bus.dma_sign : bus.cpu_sign;

        case (state_q)
            IDLE: begin
                if (dma_win || cpu_win) begin
                    bus.cpu_gnt    = cpu_win;
                    bus.dma_gnt    = dma_win;
                    bus.mem_addr2  = win_addr;
                    bus.mem_din2   = win_din;
                    bus.mem_size   = win_size;
                    bus.mem_sign   = win_sign;
                    bus.mem_write2 = win_we;
                    bus.mem_read2  = !win_we;
                    if (!win_we) begin
                        rd_addr_d  = win_addr;
                        rd_size_d  = win_size;
                        rd_sign_d  = win_sign;
                        rd_owner_d = dma_win;
                        state_d    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                bus.mem_addr2 = rd_addr_q;
                bus.mem_size  = rd_size_q;
                bus.mem_sign  = rd_sign_q;
                if (rd_owner_q) begin
                    dma_rvalid_d = 1'b1;
                    dma_rdata_d  = bus.mem_dout2;
                end else begin
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = bus.mem_dout2;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counts CPU grants that passed over a waiting DMA request.
        if (!bus.dma_req || dma_win) begin
            starve_d = '0;
        end else if (cpu_win && starve_q != LIMIT) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            rd_addr_q    <= 32'h0;
            rd_size_q    <= 2'd2;
            rd_sign_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 32'h0;
            dma_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            rd_addr_q    <= rd_addr_d;
            rd_size_q    <= rd_size_d;
            rd_sign_q    <= rd_sign_d;
            rd_owner_q   <= rd_owner_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;
endmodule
